// File: rtl/stbus_pkg.sv
// Shared ST-bus definitions: frame geometry, idle byte and channel types.
package stbus_pkg;
  localparam int STBUS_BITS_PER_CH = 8;
  localparam int STBUS_CLK_PER_BIT = 2;
  localparam int STBUS_CHANNELS    = 32;
  localparam int STBUS_FRAME_CLKS  = STBUS_CHANNELS * STBUS_BITS_PER_CH * STBUS_CLK_PER_BIT;
  localparam logic [7:0] STBUS_IDLE_BYTE = 8'hFF;

  typedef logic [7:0] ch_byte_t;
  typedef logic [4:0] ch_idx_t;
  typedef logic [8:0] frame_cnt_t;
  typedef logic [7:0] bit_idx_t;
endpackage

// File: rtl/stbus_frame_timer.sv
// ST-bus frame timer: c4 cycle counter, registered frame pulse and wrap strobe.
module stbus_frame_timer
  import stbus_pkg::*;
#(
  parameter int FRAME_CLKS = STBUS_FRAME_CLKS
) (
  input  logic     clk,
  input  logic     rst_n,
  output bit_idx_t bit_next,
  output logic     wrap,
  output logic     f0_n,
  output logic     frame_int
);
  localparam frame_cnt_t LAST = frame_cnt_t'(FRAME_CLKS - 1);

  frame_cnt_t cnt;
  frame_cnt_t cnt_next;

  // Reset parks the counter on the last cycle so the first edge starts frame 0.
  assign wrap     = (cnt == LAST);
  assign cnt_next = wrap ? '0 : cnt + 9'd1;
  assign bit_next = cnt_next[8:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= LAST;
      f0_n      <= 1'b1;
      frame_int <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      f0_n      <= (cnt_next != '0);
      frame_int <= (cnt_next == '0);
    end
  end
endmodule

// File: rtl/stbus_tx.sv
// ST-bus master transmitter: shadow/active channel buffers with frame-aligned commit
// and MSB-first serialiser. Optional per-channel muting under STBUS_TX_MUTE_EN.
module stbus_tx
  import stbus_pkg::*;
#(
  parameter int       CHANNELS  = STBUS_CHANNELS,
  parameter ch_byte_t IDLE_BYTE = STBUS_IDLE_BYTE
) (
  input  logic                c4,
  input  logic                reset_n,
  input  logic                tx_en,
  input  logic                wr_en,
  input  ch_idx_t             wr_addr,
  input  ch_byte_t            wr_data,
  input  logic                commit,
`ifdef STBUS_TX_MUTE_EN
  input  logic [CHANNELS-1:0] mute_mask,
`endif
  output logic                f0_n,
  output logic                data_to_dt,
  output logic                frame_int,
  output logic                swap_done,
  output logic                commit_pend
);
  ch_byte_t shadow [CHANNELS];
  ch_byte_t active [CHANNELS];

  bit_idx_t bit_next;
  logic     wrap;
  logic     swap;
  logic     wr_ok;
  ch_idx_t  ch_next;
  logic [2:0] sel_next;
  ch_byte_t tx_byte;
  logic     tx_bit;

  stbus_frame_timer #(
    .FRAME_CLKS(CHANNELS * STBUS_BITS_PER_CH * STBUS_CLK_PER_BIT)
  ) u_timer (
    .clk      (c4),
    .rst_n    (reset_n),
    .bit_next (bit_next),
    .wrap     (wrap),
    .f0_n     (f0_n),
    .frame_int(frame_int)
  );

  assign swap     = wrap && (commit_pend || commit);
  assign wr_ok    = wr_en && (int'(wr_addr) < CHANNELS);
  assign ch_next  = bit_next[7:3];
  assign sel_next = 3'd7 - bit_next[2:0];

  // On the swap edge the first bit already comes from the shadow being committed.
  always_comb begin
    tx_byte = swap ? shadow[ch_next] : active[ch_next];
`ifdef STBUS_TX_MUTE_EN
    if (mute_mask[ch_next]) tx_byte = IDLE_BYTE;
`endif
    tx_bit = tx_en ? tx_byte[sel_next] : 1'b1;
  end

  always_ff @(posedge c4 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= IDLE_BYTE;
        active[i] <= IDLE_BYTE;
      end
      commit_pend <= 1'b0;
      swap_done   <= 1'b0;
      data_to_dt  <= 1'b1;
    end else begin
      if (wr_ok) shadow[wr_addr] <= wr_data;
      // Non-blocking copy takes the pre-edge shadow, so a same-edge write waits.
      if (swap) begin
        for (int i = 0; i < CHANNELS; i++) active[i] <= shadow[i];
      end
      commit_pend <= swap ? 1'b0 : (commit_pend || commit);
      swap_done   <= swap;
      data_to_dt  <= tx_bit;
    end
  end
endmodule

// File: tb/tb_stbus_tx.sv
// Directed bench for stbus_tx: per-cycle scoreboard of the serial line and frame strobes.
module tb_stbus_tx;
  import stbus_pkg::*;

  logic     c4 = 1'b0;
  logic     reset_n = 1'b0;
  logic     tx_en = 1'b0;
  logic     wr_en = 1'b0;
  ch_idx_t  wr_addr = '0;
  ch_byte_t wr_data = '0;
  logic     commit = 1'b0;
`ifdef STBUS_TX_MUTE_EN
  logic [31:0] mute_mask = '0;
`endif
  logic f0_n, data_to_dt, frame_int, swap_done, commit_pend;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  ch_byte_t line [32];

  stbus_tx dut (
    .c4         (c4),
    .reset_n    (reset_n),
    .tx_en      (tx_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
`ifdef STBUS_TX_MUTE_EN
    .mute_mask  (mute_mask),
`endif
    .f0_n       (f0_n),
    .data_to_dt (data_to_dt),
    .frame_int  (frame_int),
    .swap_done  (swap_done),
    .commit_pend(commit_pend)
  );

  always #5 c4 = ~c4;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c4);
    #1;
  endtask

  function automatic ch_byte_t line_byte(input int ch);
`ifdef STBUS_TX_MUTE_EN
    if (mute_mask[ch]) return 8'hFF;
`endif
    return line[ch];
  endfunction

  task automatic chk_reset_vals();
    chk("rst_f0_n", f0_n, 1'b1);
    chk("rst_data", data_to_dt, 1'b1);
    chk("rst_frame_int", frame_int, 1'b0);
    chk("rst_swap_done", swap_done, 1'b0);
    chk("rst_commit_pend", commit_pend, 1'b0);
  endtask

  // Runs n cycles from frame position 0. commit_at / wr_at name the counter value
  // during which the strobe is held (511 means the wrap edge into this frame).
  task automatic run_frame(input int n, input int commit_at, input int wr_at,
                           input ch_idx_t wa, input ch_byte_t wd,
                           input int off_lo, input int off_hi, input logic exp_swap);
    int       cur;
    ch_byte_t b;
    logic     e;
    logic     pend;
    for (int i = 0; i < n; i++) begin
      cur     = (i + 511) % 512;
      commit  = (cur == commit_at);
      wr_en   = (cur == wr_at);
      wr_addr = wa;
      wr_data = wd;
      tx_en   = !(i >= off_lo && i <= off_hi);
      b       = line_byte(i / 16);
      e       = tx_en ? b[7 - ((i / 2) % 8)] : 1'b1;
      exp_q.push_back(e);
      pend    = (commit_at >= 0) && (commit_at < 511) && (i > commit_at);
      tick();
      chk("data_to_dt", data_to_dt, exp_q.pop_front());
      chk("f0_n", f0_n, (i != 0));
      chk("frame_int", frame_int, (i == 0));
      chk("swap_done", swap_done, (i == 0) && exp_swap);
      chk("commit_pend", commit_pend, pend);
    end
    commit = 1'b0;
    wr_en  = 1'b0;
    tx_en  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) line[i] = 8'hFF;
    tx_en = 1'b1;
    #23;
    chk_reset_vals();
    @(posedge c4);
    #3;
    reset_n = 1'b1;

    // Idle frame: line constant 1; write ch0 into shadow only.
    run_frame(512, -1, 10, 5'd0, 8'hA5, -1, -1, 1'b0);
    // Write ch31, commit mid-frame; pending until the wrap.
    run_frame(512, 300, 20, 5'd31, 8'h3C, -1, -1, 1'b0);
    line[0]  = 8'hA5;
    line[31] = 8'h3C;
    // Swapped frame; ch5 written without commit.
    run_frame(512, -1, 50, 5'd5, 8'h00, -1, -1, 1'b1);
    run_frame(512, -1, -1, 5'd0, 8'h00, -1, -1, 1'b0);
    run_frame(512, -1, -1, 5'd0, 8'h00, -1, -1, 1'b0);
    run_frame(512, 400, -1, 5'd0, 8'h00, -1, -1, 1'b0);
    line[5] = 8'h00;
    // Stage ch1 so the next swap is distinguishable from a no-op.
    run_frame(512, -1, 60, 5'd1, 8'h77, -1, -1, 1'b1);
    line[1] = 8'h77;
    // Commit and write ch0 on the wrap edge: swap takes the old shadow.
    run_frame(512, 511, 511, 5'd0, 8'h11, -1, -1, 1'b1);
    // tx_en low for positions 100..140; commit the pending ch0 write.
    run_frame(512, 200, -1, 5'd0, 8'h00, 100, 140, 1'b0);
    line[0] = 8'h11;
    run_frame(512, 300, 30, 5'd0, 8'h00, -1, -1, 1'b1);
    line[0] = 8'h00;
`ifdef STBUS_TX_MUTE_EN
    mute_mask = 32'h1;
`endif
    run_frame(512, -1, -1, 5'd0, 8'h00, -1, -1, 1'b1);
`ifdef STBUS_TX_MUTE_EN
    mute_mask = 32'h0;
`endif
    run_frame(512, -1, -1, 5'd0, 8'h00, -1, -1, 1'b0);

    // Reset mid-frame with a commit pending.
    run_frame(100, 50, 10, 5'd2, 8'h5A, -1, -1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge c4);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) line[i] = 8'hFF;
    run_frame(512, -1, -1, 5'd0, 8'h00, -1, -1, 1'b0);
    run_frame(48, -1, -1, 5'd0, 8'h00, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stbus_tx.md
Name: stbus_tx

Overview:
- ST-bus master transmitter: generates the 8 kHz frame pulse and serialises one 32-channel × 8-bit TDM frame per 125 us onto the DT-side serial line.
- Runs on c4 (4.096 MHz); one bit spans 2 c4 cycles (2.048 Mbit/s).
- Channel bytes are written from the STM/CPU side into a shadow buffer and committed atomically at the frame boundary.
- Return-direction counterpart to converter: converter receives frames, this block transmits them.

Parameters:
- CHANNELS, 32, channels per frame; frame length = CHANNELS*8*2 c4 cycles (512 at default).
- IDLE_BYTE, 8'hFF, reset and idle value for every channel byte.

Ports:
- c4  input  1  system clock, 4.096 MHz, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- tx_en  input  1  1 = transmit channel data; 0 = data_to_dt held 1 (frame timing keeps running).
- wr_en  input  1  write strobe for the shadow buffer.
- wr_addr  input  5  channel index 0..CHANNELS-1.
- wr_data  input  8  channel byte.
- commit  input  1  one-cycle request: copy shadow to active at the next frame boundary.
- f0_n  output  1  frame pulse, low for exactly one c4 cycle per frame.
- data_to_dt  output  1  serial TDM data, MSB first.
- frame_int  output  1  one-cycle pulse coincident with f0_n low.
- swap_done  output  1  one-cycle pulse in the cycle the active buffer is updated.
- commit_pend  output  1  1 while a commit is waiting for the frame boundary.

Behaviour:
- Counter cnt[8:0] runs 0..511 and wraps. Reset value is 511, so the first rising edge after reset release loads cnt=0.
- Bit index b = cnt[8:1]; channel = cnt[8:4]; bit-in-byte = 7 - cnt[3:1].
- All outputs are registered from next-cycle values:
  - f0_n = 0 iff cnt==0.
  - frame_int = 1 iff cnt==0.
  - data_to_dt = active[ch][7-cnt[3:1]] when tx_en=1, else 1. Each bit holds for cnt in {2b, 2b+1}.
  - tx_en is sampled per c4 cycle and may change mid-byte.
- Reset values: f0_n=1, data_to_dt=1, frame_int=0, swap_done=0, commit_pend=0, all shadow and active bytes = IDLE_BYTE.
- Writes:
  - wr_en=1 writes wr_data to shadow[wr_addr] at the clock edge.
  - wr_addr >= CHANNELS is ignored.
  - Shadow writes never affect the frame currently being transmitted.
- Commit:
  - commit=1 sets commit_pend.
  - On the edge where cnt wraps 511 to 0 with commit_pend=1, or with commit=1 on that same edge:
    - active <= shadow, using pre-edge shadow contents;
    - commit_pend <= 0;
    - swap_done pulses with the same timing as frame_int;
    - bit 0 of the new frame (channel 0 MSB) already comes from the new data.
  - A write and the swap on the same edge: the write lands in shadow only and appears after the next commit.
  - Repeated commit while pending: a single swap.
  - commit and a wrap on the same edge count as one swap.
- Reset mid-frame: immediate async clear of everything listed above. No partial swap. Pending commit is lost.

Optional Feature:
- Macro: STBUS_TX_MUTE_EN.
- When defined:
  - adds input mute_mask [CHANNELS-1:0];
  - any channel with its mask bit set transmits IDLE_BYTE regardless of active contents;
  - the mask is sampled per c4 cycle.
- When undefined: port absent; every channel transmits active data.

Decomposition:
- Shared package stbus_pkg holds:
  - constants: STBUS_BITS_PER_CH=8, STBUS_CLK_PER_BIT=2, STBUS_FRAME_CLKS=512, default IDLE_BYTE;
  - typedef for channel byte and channel index.
- One natural sub-module: stbus_frame_timer. It owns cnt, f0_n, frame_int and a wrap strobe, and converter can reuse it.
- The buffer, commit logic and serialiser stay in stbus_tx.

Test Plan:
- Reset release, tx_en=1, no writes -> f0_n low one cycle on the first edge, then every 512 cycles (125 us). data_to_dt constant 1.
- Write ch0=8'hA5 and ch31=8'h3C, commit mid-frame -> commit_pend=1 until the wrap; swap_done with f0_n.
  - Next frame: cycles 0..15 serialise 1,0,1,0,0,1,0,1 at 2 cycles per bit.
  - Cycles 496..511 serialise 8'h3C.
- Write ch5=8'h00 without commit -> ch5 stays 8'hFF on the line for 3 frames. After commit, 8'h00 appears in the following frame only.
- commit on the cnt=511 edge together with wr ch0=8'h11 -> swap happens with old shadow. ch0=8'h11 appears only after a second commit.
- tx_en dropped during cycles 100..140 -> data_to_dt=1 there; f0_n period unaffected. Assert reset_n mid-frame -> outputs at reset values immediately and commit_pend cleared.
- STBUS_TX_MUTE_EN defined, mute_mask[0]=1, ch0=8'h00 committed -> ch0 transmits 8'hFF. Clear the mask -> 8'h00 from the next byte slot.
